lsu_mem_master: RTL and testbench

- Load/store initiator driving the 32-bit data memory port (async read, write on rising clk edge, word index = address[15:2]).
- Accepts one CPU request at a time over a valid/ready handshake and supports byte, halfword and word accesses.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Sits between the execute stage and the data memory; the pipeline stalls while req_ready=0.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/lsu_mem_master.sv | 133 +++++++++++++
 tb/tb_lsu_mem_master.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states
// and the request legality check.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsuStateT;

  // A request is rejected when the size is illegal, the address is not
  // naturally aligned for the size, or it falls outside the backed memory.
  function automatic logic isBadRequest(input logic [1:0] size,
                                        input logic [31:0] addr,
                                        input int addrBits);
    logic outOfRange;
    logic misaligned;
    outOfRange = (addrBits < 32) ? ((addr >> addrBits) != 32'd0) : 1'b0;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    return outOfRange | misaligned;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit: merges store data into an
// existing memory word and extracts/extends load data from a word.
// Little-endian: byte lane k sits in bits [8k+7:8k].
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  byteOff,
  input  logic        isUnsigned,
  output logic [31:0] mergedWord,
  output logic [31:0] loadData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Replace only the addressed lane(s) of the old word with the store data.
  always_comb begin
    mergedWord = oldWord;
    case (size)
      SZ_BYTE: begin
        case (byteOff)
          2'd0: mergedWord[7:0]   = wdata[7:0];
          2'd1: mergedWord[15:8]  = wdata[7:0];
          2'd2: mergedWord[23:16] = wdata[7:0];
          default: mergedWord[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (byteOff[1]) mergedWord[31:16] = wdata[15:0];
        else            mergedWord[15:0]  = wdata[15:0];
      end
      SZ_WORD: mergedWord = wdata;
      default: mergedWord = oldWord;
    endcase
  end

  // Pick out the addressed lane and sign- or zero-extend it to 32 bits.
  always_comb begin
    case (byteOff)
      2'd0: byteSel = oldWord[7:0];
      2'd1: byteSel = oldWord[15:8];
      2'd2: byteSel = oldWord[23:16];
      default: byteSel = oldWord[31:24];
    endcase
    halfSel = byteOff[1] ? oldWord[31:16] : oldWord[15:0];
    case (size)
      SZ_BYTE: loadData = {{24{byteSel[7] & ~isUnsigned}}, byteSel};
      SZ_HALF: loadData = {{16{halfSel[15] & ~isUnsigned}}, halfSel};
      SZ_WORD: loadData = oldWord;
      default: loadData = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and the data memory.
// One request at a time; sub-word stores are done as read-modify-write.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_writeEnable,
  output logic        mem_MemRead,
  input  logic [31:0] mem_data
);

  lsuStateT    state;
  logic        writeReg;
  logic [1:0]  sizeReg;
  logic        unsignedReg;
  logic [31:0] addrReg;
  logic [31:0] wdataReg;
  logic        memWriteReg;
  logic        memReadReg;
  logic [31:0] memWdataReg;
  logic        respValidReg;
  logic        respErrReg;
  logic [31:0] respRdataReg;
  logic [31:0] mergedWord;
  logic [31:0] loadData;
  logic        reqBad;

  assign reqBad = isBadRequest(req_size, req_addr, MEM_ADDR_BITS);

  // The read word from memory is steered directly at the RD edge, so the
  // captured read data lands in the write-data or response register.
  lsu_lane_align uAlign (
    .oldWord    (mem_data),
    .wdata      (wdataReg),
    .size       (sizeReg),
    .byteOff    (addrReg[1:0]),
    .isUnsigned (unsignedReg),
    .mergedWord (mergedWord),
    .loadData   (loadData)
  );

  assign req_ready       = (state == IDLE);
  assign resp_valid      = respValidReg;
  assign resp_rdata      = respRdataReg;
  assign resp_err        = respErrReg;
  assign mem_address     = {addrReg[31:2], 2'b00};
  assign mem_writeData   = memWdataReg;
  assign mem_MemRead     = memReadReg;
  // Gating with reset guarantees no write lands on an edge where reset is held.
  assign mem_writeEnable = memWriteReg & rst_n;

  // Request FSM with registered memory strobes and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      writeReg     <= 1'b0;
      sizeReg      <= 2'b00;
      unsignedReg  <= 1'b0;
      addrReg      <= 32'd0;
      wdataReg     <= 32'd0;
      memWriteReg  <= 1'b0;
      memReadReg   <= 1'b0;
      memWdataReg  <= 32'd0;
      respValidReg <= 1'b0;
      respErrReg   <= 1'b0;
      respRdataReg <= 32'd0;
    end else begin
      memWriteReg  <= 1'b0;
      memReadReg   <= 1'b0;
      respValidReg <= 1'b0;
      respErrReg   <= 1'b0;
      respRdataReg <= 32'd0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            writeReg    <= req_write;
            sizeReg     <= req_size;
            unsignedReg <= req_unsigned;
            addrReg     <= req_addr;
            wdataReg    <= req_wdata;
            if (reqBad) begin
              state        <= RESP;
              respValidReg <= 1'b1;
              respErrReg   <= 1'b1;
            end else if (req_write && (req_size == SZ_WORD)) begin
              state       <= WR;
              memWriteReg <= 1'b1;
              memWdataReg <= req_wdata;
            end else begin
              state      <= RD;
              memReadReg <= 1'b1;
            end
          end
        end
        RD: begin
          if (writeReg) begin
            state       <= WR;
            memWriteReg <= 1'b1;
            memWdataReg <= mergedWord;
          end else begin
            state        <= RESP;
            respValidReg <= 1'b1;
            respRdataReg <= loadData;
          end
        end
        WR: begin
          state        <= RESP;
          respValidReg <= 1'b1;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed vector table, reset and
// back-to-back sequences, then random traffic against a byte-level model.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_writeEnable;
  logic        mem_MemRead;
  logic [31:0] mem_data;

  logic [31:0] mem [0:16383];
  logic [7:0]  refByte [0:65535];

  int compareCount = 0;
  int failCount = 0;
  int memReadCount = 0;
  int memWriteCount = 0;
  int acceptCount = 0;
  int badAddrCount = 0;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
  } vecT;

  vecT vecs [16];

  lsu_mem_master #(.MEM_ADDR_BITS(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_address     (mem_address),
    .mem_writeData   (mem_writeData),
    .mem_writeEnable (mem_writeEnable),
    .mem_MemRead     (mem_MemRead),
    .mem_data        (mem_data)
  );

  always #5 clk = ~clk;

  assign mem_data = mem[mem_address[15:2]];

  // Memory array plus activity counters and a memory-address sanity monitor.
  always @(posedge clk) begin
    if (mem_MemRead) memReadCount++;
    if (mem_writeEnable) begin
      memWriteCount++;
      mem[mem_address[15:2]] <= mem_writeData;
    end
    if (rst_n && req_valid && req_ready) acceptCount++;
    if ((mem_MemRead || mem_writeEnable) &&
        ((mem_address[31:16] != 16'd0) || (mem_address[1:0] != 2'b00)))
      badAddrCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour on a byte-addressed little-endian memory.
  task automatic modelAccess(input logic write, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err, output int lat,
                             output int reads, output int writes);
    int nBytes;
    logic [63:0] val;
    case (size)
      2'd0: nBytes = 1;
      2'd1: nBytes = 2;
      2'd2: nBytes = 4;
      default: nBytes = 0;
    endcase
    if (nBytes == 0) err = 1'b1;
    else err = ((addr % nBytes) != 0) || (addr > 32'h0000_FFFF);
    rdata = 32'd0;
    if (err) begin
      lat = 1; reads = 0; writes = 0;
    end else if (write) begin
      for (int i = 0; i < nBytes; i++) refByte[int'(addr[15:0]) + i] = wdata[8*i +: 8];
      lat = (nBytes == 4) ? 2 : 3;
      reads = (nBytes == 4) ? 0 : 1;
      writes = 1;
    end else begin
      val = 64'd0;
      for (int i = 0; i < nBytes; i++) val = val | (64'(refByte[int'(addr[15:0]) + i]) << (8*i));
      if (!uns && val[8*nBytes-1]) val = val | ~((64'd1 << (8*nBytes)) - 64'd1);
      rdata = val[31:0];
      lat = 2; reads = 1; writes = 0;
    end
  endtask

  task automatic applyStimulus(input logic write, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat,
                               output int reads, output int writes);
    int waitCnt;
    int rd0;
    int wr0;
    @(negedge clk);
    req_write = write; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 20) checkOutput("readyTimeout", 32'd1, 32'd0);
    rd0 = memReadCount;
    wr0 = memWriteCount;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    rdata = resp_rdata;
    err = resp_err;
    reads = memReadCount - rd0;
    writes = memWriteCount - wr0;
  endtask

  task automatic runAndCheck(input string tag, input logic write, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] expRdata, gotRdata;
    logic expErr, gotErr;
    int expLat, gotLat, expReads, gotReads, expWrites, gotWrites;
    modelAccess(write, size, uns, addr, wdata, expRdata, expErr, expLat, expReads, expWrites);
    applyStimulus(write, size, uns, addr, wdata, gotRdata, gotErr, gotLat, gotReads, gotWrites);
    checkOutput({tag, ".rdata"}, gotRdata, expRdata);
    checkOutput({tag, ".err"}, 32'(gotErr), 32'(expErr));
    checkOutput({tag, ".lat"}, 32'(gotLat), 32'(expLat));
    checkOutput({tag, ".reads"}, 32'(gotReads), 32'(expReads));
    checkOutput({tag, ".writes"}, 32'(gotWrites), 32'(expWrites));
  endtask

  initial begin
    logic [31:0] gotRdata, mRdata, expWord, data;
    logic gotErr, mErr, sawResp;
    int gotLat, gotReads, gotWrites, mLat, mReads, mWrites, busy, guard, acc0;
    logic        bWr [4];
    logic [1:0]  bSz [4];
    logic [31:0] bAd [4];
    logic [31:0] bWd [4];
    int          bLat [4];
    logic [31:0] bExp [4];
    logic [1:0]  rSize;
    logic [31:0] rAddr;

    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    for (int i = 0; i < 65536; i++) refByte[i] = 8'd0;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h12, 32'h55, 32'h0, 1'b0, 3};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0, 2};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 2};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h0000DE55, 1'b0, 2};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h00010000, 32'h0, 32'h0, 1'b1, 1};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h1234, 32'h0, 1'b0, 3};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, 2};
    vecs[14] = '{1'b1, 2'd2, 1'b0, 32'h0000FFFC, 32'hA5A5A5A5, 32'h0, 1'b0, 2};
    vecs[15] = '{1'b0, 2'd0, 1'b0, 32'h0000FFFF, 32'h0, 32'hFFFFFFA5, 1'b0, 2};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst.ready", 32'(req_ready), 32'd1);
    checkOutput("rst.respValid", 32'(resp_valid), 32'd0);
    checkOutput("rst.respRdata", resp_rdata, 32'd0);
    checkOutput("rst.respErr", 32'(resp_err), 32'd0);
    checkOutput("rst.memRead", 32'(mem_MemRead), 32'd0);
    checkOutput("rst.memWe", 32'(mem_writeEnable), 32'd0);
    checkOutput("rst.memAddr", mem_address, 32'd0);
    checkOutput("rst.memWdata", mem_writeData, 32'd0);
    rst_n = 1'b1;

    // Directed vector table
    for (int v = 0; v < 16; v++) begin
      modelAccess(vecs[v].write, vecs[v].size, vecs[v].uns, vecs[v].addr, vecs[v].wdata,
                  mRdata, mErr, mLat, mReads, mWrites);
      applyStimulus(vecs[v].write, vecs[v].size, vecs[v].uns, vecs[v].addr, vecs[v].wdata,
                    gotRdata, gotErr, gotLat, gotReads, gotWrites);
      checkOutput($sformatf("vec%0d.rdata", v), gotRdata, vecs[v].expRdata);
      checkOutput($sformatf("vec%0d.err", v), 32'(gotErr), 32'(vecs[v].expErr));
      checkOutput($sformatf("vec%0d.lat", v), 32'(gotLat), 32'(vecs[v].expLat));
      if (vecs[v].expErr) begin
        checkOutput($sformatf("vec%0d.errReads", v), 32'(gotReads), 32'd0);
        checkOutput($sformatf("vec%0d.errWrites", v), 32'(gotWrites), 32'd0);
      end
    end

    // Reset during the WR cycle of a byte store aborts the write and response
    runAndCheck("pre.rst", 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h22; req_wdata = 32'h77; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("abort.rdPhase", 32'(mem_MemRead), 32'd1);
    @(negedge clk);
    checkOutput("abort.wrPhase", 32'(mem_writeEnable), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort.weGated", 32'(mem_writeEnable), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort.ready", 32'(req_ready), 32'd1);
    sawResp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) sawResp = 1'b1;
      @(negedge clk);
    end
    checkOutput("abort.noResp", 32'(sawResp), 32'd0);
    checkOutput("abort.memWord8", mem[8], 32'h11223344);
    runAndCheck("post.rst", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

    // Back-to-back requests with req_valid held high
    bWr = '{1'b1, 1'b0, 1'b1, 1'b0};
    bSz = '{2'd2, 2'd2, 2'd0, 2'd2};
    bAd = '{32'h30, 32'h30, 32'h31, 32'h30};
    bWd = '{32'hCAFE0001, 32'h0, 32'h99, 32'h0};
    bLat = '{2, 2, 3, 2};
    bExp = '{32'h0, 32'hCAFE0001, 32'h0, 32'hCAFE9901};
    for (int i = 0; i < 4; i++)
      modelAccess(bWr[i], bSz[i], 1'b0, bAd[i], bWd[i], mRdata, mErr, mLat, mReads, mWrites);
    @(negedge clk);
    req_write = bWr[0]; req_size = bSz[0]; req_unsigned = 1'b0;
    req_addr = bAd[0]; req_wdata = bWd[0]; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    acc0 = acceptCount;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        req_write = bWr[i+1]; req_size = bSz[i+1];
        req_addr = bAd[i+1]; req_wdata = bWd[i+1];
      end else begin
        req_valid = 1'b0;
      end
      busy = 0;
      data = 32'hBAD0BAD0;
      while (!req_ready && busy < 10) begin
        if (resp_valid) data = resp_rdata;
        busy++;
        @(negedge clk);
      end
      checkOutput($sformatf("b2b%0d.busy", i), 32'(busy), 32'(bLat[i]));
      checkOutput($sformatf("b2b%0d.rdata", i), data, bExp[i]);
    end
    @(negedge clk);
    checkOutput("b2b.accepts", 32'(acceptCount - acc0), 32'd4);

    // Random traffic against the byte-level model
    for (int n = 0; n < 80; n++) begin
      rSize = ($urandom_range(0, 15) == 15) ? 2'd3 : 2'($urandom_range(0, 2));
      rAddr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) rAddr = rAddr | (32'd1 << $urandom_range(16, 31));
      runAndCheck($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), rSize,
                  1'($urandom_range(0, 1)), rAddr, $urandom);
    end

    // Final memory image against the model
    @(negedge clk);
    for (int w = 0; w < 16; w++) begin
      expWord = {refByte[4*w+3], refByte[4*w+2], refByte[4*w+1], refByte[4*w]};
      checkOutput($sformatf("memWord%0d", w), mem[w], expWord);
    end
    expWord = {refByte[65535], refByte[65534], refByte[65533], refByte[65532]};
    checkOutput("memWordTop", mem[16383], expWord);
    checkOutput("memAddrLegal", 32'(badAddrCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
